// File: rtl/vga_mix_pkg.sv
// Shared types and helpers for the VGA layer mixer: pixel format, 50% blend,
// background top-layer code and the mixer latency for sideband alignment.
package vga_mix_pkg;

    localparam int RGB_W = 12;
    localparam int CH_W  = 4;
    localparam int N_CH  = RGB_W / CH_W;

    localparam logic [2:0] TOP_NONE    = 3'd7;
    localparam int         MIX_LATENCY = 2;

    typedef logic [RGB_W-1:0] rgb_t;

    // Per-channel (a+b)>>1; the extra bit keeps the carry so 15+15 gives 15.
    function automatic rgb_t rgb_avg(input rgb_t a, input rgb_t b);
        rgb_t          r;
        logic [CH_W:0] s;
        r = '0;
        for (int c = 0; c < N_CH; c++) begin
            s = {1'b0, a[c*CH_W +: CH_W]} + {1'b0, b[c*CH_W +: CH_W]};
            r[c*CH_W +: CH_W] = s[CH_W:1];
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_mix_resolve.sv
// Combinational priority/blend resolver: paints layers from the lowest priority
// (highest index) up to layer 0 over the background colour.
module vga_mix_resolve
    import vga_mix_pkg::*;
#(
    parameter int                  N_LAYERS   = 4,
    parameter rgb_t                BG_RGB     = 12'h000,
    parameter logic [N_LAYERS-1:0] BLEND_MASK = '0
) (
    input  logic [N_LAYERS*RGB_W-1:0] rgb_i,
    input  logic [N_LAYERS-1:0]       valid_i,
    input  logic [N_LAYERS-1:0]       en_i,
    output rgb_t                      rgb_o,
    output logic [2:0]                top_o
);

    rgb_t       c;
    logic [2:0] top;

    always_comb begin
        c   = BG_RGB;
        top = TOP_NONE;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (valid_i[i] && en_i[i]) begin
                if (BLEND_MASK[i]) begin
                    c = rgb_avg(rgb_i[i*RGB_W +: RGB_W], c);
                end else begin
                    c = rgb_i[i*RGB_W +: RGB_W];
                end
                top = 3'(i);
            end
        end
    end

    assign rgb_o = c;
    assign top_o = top;

endmodule

// File: rtl/vga_layer_mixer.sv
// N-layer priority compositor with a two-stage pipeline, frame-synchronous
// layer-enable shadow mask and a completed-frame counter.
module vga_layer_mixer #(
    parameter int                  N_LAYERS   = 4,
    parameter int                  RGB_W      = 12,
    parameter logic [RGB_W-1:0]    BG_RGB     = 12'h000,
    parameter logic [N_LAYERS-1:0] BLEND_MASK = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [10:0]               hcount_in,
    input  logic [10:0]               vcount_in,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      hblnk_in,
    input  logic                      vblnk_in,
    input  logic [N_LAYERS*RGB_W-1:0] layer_rgb_in,
    input  logic [N_LAYERS-1:0]       layer_valid_in,
    input  logic [N_LAYERS-1:0]       layer_en_req,
    input  logic                      layer_en_wr,
    output logic [N_LAYERS-1:0]       layer_en_active,
    output logic [10:0]               hcount_out,
    output logic [10:0]               vcount_out,
    output logic                      hsync_out,
    output logic                      vsync_out,
    output logic                      hblnk_out,
    output logic                      vblnk_out,
    output logic [RGB_W-1:0]          rgb_out,
    output logic [2:0]                top_layer,
    output logic [15:0]               frame_cnt
);
    import vga_mix_pkg::*;

    logic [10:0]               hcount_s1_q, vcount_s1_q;
    logic                      hsync_s1_q, vsync_s1_q, hblnk_s1_q, vblnk_s1_q;
    logic [N_LAYERS*RGB_W-1:0] rgb_s1_q;
    logic [N_LAYERS-1:0]       valid_s1_q, en_s1_q;

    logic [10:0]               hcount_s2_q, vcount_s2_q;
    logic                      hsync_s2_q, vsync_s2_q, hblnk_s2_q, vblnk_s2_q;
    logic [RGB_W-1:0]          rgb_s2_q;
    logic [2:0]                top_s2_q;

    logic [N_LAYERS-1:0]       en_active_q, en_active_d;
    logic [N_LAYERS-1:0]       pend_mask_q, pend_mask_d;
    logic                      pend_flag_q, pend_flag_d;
    logic [15:0]               frame_cnt_q, frame_cnt_d;

    logic                      frame_edge;
    logic [RGB_W-1:0]          res_rgb;
    logic [2:0]                res_top;

    assign frame_edge = vblnk_in & ~vblnk_s1_q;

    // A write landing on the frame edge bypasses the pending slot.
    always_comb begin
        en_active_d = en_active_q;
        pend_mask_d = pend_mask_q;
        pend_flag_d = pend_flag_q;
        frame_cnt_d = frame_cnt_q;
        if (frame_edge) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            pend_flag_d = 1'b0;
            if (layer_en_wr) begin
                en_active_d = layer_en_req;
            end else if (pend_flag_q) begin
                en_active_d = pend_mask_q;
            end
        end else if (layer_en_wr) begin
            pend_mask_d = layer_en_req;
            pend_flag_d = 1'b1;
        end
    end

    vga_mix_resolve #(
        .N_LAYERS   (N_LAYERS),
        .BG_RGB     (BG_RGB),
        .BLEND_MASK (BLEND_MASK)
    ) u_resolve (
        .rgb_i   (rgb_s1_q),
        .valid_i (valid_s1_q),
        .en_i    (en_s1_q),
        .rgb_o   (res_rgb),
        .top_o   (res_top)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_s1_q <= '0;
            vcount_s1_q <= '0;
            hsync_s1_q  <= 1'b0;
            vsync_s1_q  <= 1'b0;
            hblnk_s1_q  <= 1'b0;
            vblnk_s1_q  <= 1'b0;
            rgb_s1_q    <= '0;
            valid_s1_q  <= '0;
            en_s1_q     <= '1;
            hcount_s2_q <= '0;
            vcount_s2_q <= '0;
            hsync_s2_q  <= 1'b0;
            vsync_s2_q  <= 1'b0;
            hblnk_s2_q  <= 1'b0;
            vblnk_s2_q  <= 1'b0;
            rgb_s2_q    <= '0;
            top_s2_q    <= TOP_NONE;
            en_active_q <= '1;
            pend_mask_q <= '0;
            pend_flag_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            hcount_s1_q <= hcount_in;
            vcount_s1_q <= vcount_in;
            hsync_s1_q  <= hsync_in;
            vsync_s1_q  <= vsync_in;
            hblnk_s1_q  <= hblnk_in;
            vblnk_s1_q  <= vblnk_in;
            rgb_s1_q    <= layer_rgb_in;
            valid_s1_q  <= layer_valid_in;
            en_s1_q     <= en_active_q;
            hcount_s2_q <= hcount_s1_q;
            vcount_s2_q <= vcount_s1_q;
            hsync_s2_q  <= hsync_s1_q;
            vsync_s2_q  <= vsync_s1_q;
            hblnk_s2_q  <= hblnk_s1_q;
            vblnk_s2_q  <= vblnk_s1_q;
            rgb_s2_q    <= (hblnk_s1_q || vblnk_s1_q) ? '0 : res_rgb;
            top_s2_q    <= res_top;
            en_active_q <= en_active_d;
            pend_mask_q <= pend_mask_d;
            pend_flag_q <= pend_flag_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign hcount_out      = hcount_s2_q;
    assign vcount_out      = vcount_s2_q;
    assign hsync_out       = hsync_s2_q;
    assign vsync_out       = vsync_s2_q;
    assign hblnk_out       = hblnk_s2_q;
    assign vblnk_out       = vblnk_s2_q;
    assign rgb_out         = rgb_s2_q;
    assign top_layer       = top_s2_q;
    assign frame_cnt       = frame_cnt_q;
    assign layer_en_active = en_active_q;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Testbench for vga_layer_mixer: two instances (opaque over 12'h123, and layer 0
// blended over black) driven in parallel by table vectors, directed sequences and random stimulus.
module tb_vga_layer_mixer;

    localparam int N = 4;
    localparam int W = 12;

    logic           clk = 1'b0;
    logic           rst;
    logic [10:0]    hcount_in, vcount_in;
    logic           hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [N*W-1:0] layer_rgb_in;
    logic [N-1:0]   layer_valid_in, layer_en_req;
    logic           layer_en_wr;

    logic [N-1:0]   act_a, act_b;
    logic [10:0]    hc_a, vc_a, hc_b, vc_b;
    logic           hs_a, vs_a, hb_a, vb_a, hs_b, vs_b, hb_b, vb_b;
    logic [W-1:0]   rgb_a, rgb_b;
    logic [2:0]     top_a, top_b;
    logic [15:0]    fc_a, fc_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_layer_mixer #(.N_LAYERS(N), .RGB_W(W), .BG_RGB(12'h123), .BLEND_MASK(4'b0000)) dut_a (
        .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .layer_rgb_in(layer_rgb_in), .layer_valid_in(layer_valid_in),
        .layer_en_req(layer_en_req), .layer_en_wr(layer_en_wr), .layer_en_active(act_a),
        .hcount_out(hc_a), .vcount_out(vc_a), .hsync_out(hs_a), .vsync_out(vs_a),
        .hblnk_out(hb_a), .vblnk_out(vb_a), .rgb_out(rgb_a), .top_layer(top_a), .frame_cnt(fc_a)
    );

    vga_layer_mixer #(.N_LAYERS(N), .RGB_W(W), .BG_RGB(12'h000), .BLEND_MASK(4'b0001)) dut_b (
        .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .layer_rgb_in(layer_rgb_in), .layer_valid_in(layer_valid_in),
        .layer_en_req(layer_en_req), .layer_en_wr(layer_en_wr), .layer_en_active(act_b),
        .hcount_out(hc_b), .vcount_out(vc_b), .hsync_out(hs_b), .vsync_out(vs_b),
        .hblnk_out(hb_b), .vblnk_out(vb_b), .rgb_out(rgb_b), .top_layer(top_b), .frame_cnt(fc_b)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [47:0] rgb;
        logic        hblnk;
        logic        hsync;
        logic [11:0] ea;
        logic [2:0]  ta;
        logic [11:0] eb;
        logic [2:0]  tb;
    } vec_t;

    typedef struct {
        logic [11:0] ra;
        logic [2:0]  ta;
        logic [11:0] rb;
        logic [2:0]  tb;
        logic [10:0] hc;
        logic [10:0] vc;
        logic [3:0]  strb;
    } exp_t;

    vec_t vt[12];
    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hcount_in = '0; vcount_in = '0;
        hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
        layer_rgb_in = '0; layer_valid_in = '0; layer_en_req = '0; layer_en_wr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic int avg_ch(input int a, input int b);
        return (a + b) / 2;
    endfunction

    // Reference compositor: paint from the bottom layer up, layer 0 ends on top.
    function automatic void ref_pix(input logic [47:0] rgb, input logic [3:0] valid,
                                    input logic [3:0] en, input logic [3:0] blend,
                                    input logic [11:0] bg, output logic [11:0] c,
                                    output logic [2:0] top);
        logic [11:0] p;
        c   = bg;
        top = 3'd7;
        for (int i = 3; i >= 0; i--) begin
            if (valid[i] && en[i]) begin
                p = rgb[i*12 +: 12];
                if (blend[i]) begin
                    c = {4'(avg_ch(int'(p[11:8]), int'(c[11:8]))),
                         4'(avg_ch(int'(p[7:4]),  int'(c[7:4]))),
                         4'(avg_ch(int'(p[3:0]),  int'(c[3:0])))};
                end else begin
                    c = p;
                end
                top = 3'(i);
            end
        end
    endfunction

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  m_act, m_pmask;
        logic        m_pflag, m_prev_v, fedge;
        logic [15:0] m_fc;
        exp_t        e;

        vt[0]  = '{4'b0101, {12'h000, 12'h0F0, 12'h000, 12'hF00}, 1'b0, 1'b0, 12'hF00, 3'd0, 12'h770, 3'd0};
        vt[1]  = '{4'b0100, {12'h000, 12'h0F0, 12'h000, 12'hF00}, 1'b0, 1'b1, 12'h0F0, 3'd2, 12'h0F0, 3'd2};
        vt[2]  = '{4'b0011, {12'h000, 12'h000, 12'h0F0, 12'hF00}, 1'b0, 1'b0, 12'hF00, 3'd0, 12'h770, 3'd0};
        vt[3]  = '{4'b0000, {12'h000, 12'h000, 12'h0F0, 12'hF00}, 1'b0, 1'b1, 12'h123, 3'd7, 12'h000, 3'd7};
        vt[4]  = '{4'b0000, {12'h000, 12'h000, 12'h000, 12'h000}, 1'b1, 1'b0, 12'h000, 3'd7, 12'h000, 3'd7};
        vt[5]  = '{4'b0001, {12'h000, 12'h000, 12'h000, 12'hF00}, 1'b1, 1'b1, 12'h000, 3'd0, 12'h000, 3'd0};
        vt[6]  = '{4'b0001, {12'h000, 12'h000, 12'h000, 12'hF00}, 1'b0, 1'b0, 12'hF00, 3'd0, 12'h700, 3'd0};
        vt[7]  = '{4'b1001, {12'h456, 12'h000, 12'h000, 12'hABC}, 1'b0, 1'b1, 12'hABC, 3'd0, 12'h789, 3'd0};
        vt[8]  = '{4'b1110, {12'h222, 12'h111, 12'hFFF, 12'h000}, 1'b0, 1'b0, 12'hFFF, 3'd1, 12'hFFF, 3'd1};
        vt[9]  = '{4'b0001, {12'h000, 12'h000, 12'h000, 12'h1E1}, 1'b0, 1'b1, 12'h1E1, 3'd0, 12'h070, 3'd0};
        vt[10] = '{4'b0011, {12'h000, 12'h000, 12'hFFF, 12'hFFF}, 1'b0, 1'b0, 12'hFFF, 3'd0, 12'hFFF, 3'd0};
        vt[11] = '{4'b1000, {12'hFFF, 12'h000, 12'h000, 12'h000}, 1'b0, 1'b1, 12'hFFF, 3'd3, 12'hFFF, 3'd3};

        do_reset();
        chk("reset_rgb", 32'(rgb_a), 32'h0);
        chk("reset_top", 32'(top_a), 32'd7);
        chk("reset_fc", 32'(fc_a), 32'd0);
        chk("reset_act", 32'(act_a), 32'hF);

        // Table vectors, each held for the two-cycle pipeline.
        for (int i = 0; i < 12; i++) begin
            layer_valid_in = vt[i].valid;
            layer_rgb_in   = vt[i].rgb;
            hblnk_in       = vt[i].hblnk;
            hsync_in       = vt[i].hsync;
            tick();
            tick();
            chk($sformatf("vec%0d_rgb_a", i), 32'(rgb_a), 32'(vt[i].ea));
            chk($sformatf("vec%0d_top_a", i), 32'(top_a), 32'(vt[i].ta));
            chk($sformatf("vec%0d_rgb_b", i), 32'(rgb_b), 32'(vt[i].eb));
            chk($sformatf("vec%0d_top_b", i), 32'(top_b), 32'(vt[i].tb));
            chk($sformatf("vec%0d_hsync", i), 32'(hs_a), 32'(vt[i].hsync));
        end

        // Mask change requested mid-frame takes effect only at the vblnk rise.
        do_reset();
        layer_rgb_in = 48'h000_000_000_F00;
        layer_valid_in = 4'b0001;
        tick(); tick();
        chk("mask_pre_rgb", 32'(rgb_a), 32'hF00);
        layer_en_req = 4'b1110; layer_en_wr = 1'b1;
        tick();
        layer_en_wr = 1'b0;
        tick(); tick(); tick();
        chk("mask_hold_act", 32'(act_a), 32'hF);
        chk("mask_hold_rgb", 32'(rgb_a), 32'hF00);
        chk("mask_hold_top", 32'(top_a), 32'd0);
        vblnk_in = 1'b1;
        tick();
        chk("mask_edge_act", 32'(act_a), 32'hE);
        chk("mask_edge_fc", 32'(fc_a), 32'd1);
        tick();
        chk("mask_edgepix_top", 32'(top_a), 32'd0);
        chk("mask_edgepix_rgb", 32'(rgb_a), 32'h0);
        tick();
        chk("mask_after_top", 32'(top_a), 32'd7);
        vblnk_in = 1'b0;
        tick(); tick();
        chk("mask_after_rgb", 32'(rgb_a), 32'h123);
        chk("mask_after_top2", 32'(top_a), 32'd7);

        // Last write in a frame wins; a write on the edge applies at that edge.
        layer_en_req = 4'b0011; layer_en_wr = 1'b1; tick();
        layer_en_wr = 1'b0; tick();
        layer_en_req = 4'b0101; layer_en_wr = 1'b1; tick();
        layer_en_wr = 1'b0; tick();
        chk("multi_hold_act", 32'(act_a), 32'hE);
        vblnk_in = 1'b1; tick();
        chk("multi_edge_act", 32'(act_a), 32'h5);
        vblnk_in = 1'b0; tick();
        vblnk_in = 1'b1; layer_en_req = 4'b1010; layer_en_wr = 1'b1; tick();
        layer_en_wr = 1'b0;
        chk("coinc_act", 32'(act_a), 32'hA);
        chk("three_frames_fc", 32'(fc_a), 32'd3);
        vblnk_in = 1'b0; tick();
        vblnk_in = 1'b1; tick();
        chk("no_stale_pending_act", 32'(act_a), 32'hA);
        chk("four_frames_fc", 32'(fc_a), 32'd4);

        // Reset mid-line with live inputs, then counter wrap.
        vblnk_in = 1'b0; hcount_in = 11'd300; vcount_in = 11'd100;
        hsync_in = 1'b1; vsync_in = 1'b1; layer_valid_in = 4'b1111;
        tick(); tick();
        rst = 1'b1; vblnk_in = 1'b1; hblnk_in = 1'b1;
        tick();
        chk("rst_hc", 32'(hc_a), 32'd0);
        chk("rst_vc", 32'(vc_a), 32'd0);
        chk("rst_strobes", 32'({hs_a, vs_a, hb_a, vb_a}), 32'h0);
        chk("rst_rgb", 32'(rgb_a), 32'h0);
        chk("rst_top", 32'(top_a), 32'd7);
        chk("rst_fc", 32'(fc_a), 32'd0);
        chk("rst_act", 32'(act_a), 32'hF);
        rst = 1'b0;
        tick();
        chk("post_rst_edge_fc", 32'(fc_a), 32'd1);
        vblnk_in = 1'b0;
        tick();
        force dut_a.frame_cnt_q = 16'hFFFF;
        #1;
        release dut_a.frame_cnt_q;
        tick();
        chk("wrap_hold_fc", 32'(fc_a), 32'hFFFF);
        vblnk_in = 1'b1;
        tick();
        chk("wrap_fc", 32'(fc_a), 32'h0);

        // Randomized run against the reference model.
        do_reset();
        m_act = 4'hF; m_pmask = 4'h0; m_pflag = 1'b0; m_prev_v = 1'b0; m_fc = 16'd0;
        q.delete();
        for (int k = 0; k < 3000; k++) begin
            hcount_in      = 11'($urandom);
            vcount_in      = 11'($urandom);
            hsync_in       = 1'($urandom);
            vsync_in       = 1'($urandom);
            hblnk_in       = ($urandom_range(3) == 0);
            if ($urandom_range(9) == 0) vblnk_in = !vblnk_in;
            layer_rgb_in   = {16'($urandom), 32'($urandom)};
            layer_valid_in = 4'($urandom);
            layer_en_req   = 4'($urandom);
            layer_en_wr    = ($urandom_range(5) == 0);

            ref_pix(layer_rgb_in, layer_valid_in, m_act, 4'b0000, 12'h123, e.ra, e.ta);
            ref_pix(layer_rgb_in, layer_valid_in, m_act, 4'b0001, 12'h000, e.rb, e.tb);
            if (hblnk_in || vblnk_in) begin
                e.ra = 12'h000;
                e.rb = 12'h000;
            end
            e.hc   = hcount_in;
            e.vc   = vcount_in;
            e.strb = {hsync_in, vsync_in, hblnk_in, vblnk_in};
            q.push_back(e);

            fedge = vblnk_in && !m_prev_v;
            if (fedge) begin
                m_fc = m_fc + 16'd1;
                if (layer_en_wr) m_act = layer_en_req;
                else if (m_pflag) m_act = m_pmask;
                m_pflag = 1'b0;
            end else if (layer_en_wr) begin
                m_pmask = layer_en_req;
                m_pflag = 1'b1;
            end
            m_prev_v = vblnk_in;

            tick();
            chk($sformatf("rnd%0d_act", k), 32'(act_a), 32'(m_act));
            chk($sformatf("rnd%0d_fc", k), 32'(fc_a), 32'(m_fc));
            if (q.size() == 2) begin
                e = q.pop_front();
                chk($sformatf("rnd%0d_rgb_a", k), 32'(rgb_a), 32'(e.ra));
                chk($sformatf("rnd%0d_top_a", k), 32'(top_a), 32'(e.ta));
                chk($sformatf("rnd%0d_rgb_b", k), 32'(rgb_b), 32'(e.rb));
                chk($sformatf("rnd%0d_top_b", k), 32'(top_b), 32'(e.tb));
                chk($sformatf("rnd%0d_hc", k), 32'(hc_a), 32'(e.hc));
                chk($sformatf("rnd%0d_vc", k), 32'(vc_a), 32'(e.vc));
                chk($sformatf("rnd%0d_strobes", k), 32'({hs_a, vs_a, hb_a, vb_a}), 32'(e.strb));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_layer_mixer.md
Name: vga_layer_mixer

Overview:
- Parametrised N-layer priority compositor for the VGA pipeline. It replaces the fixed chain of per-stage rgb pass-through with one block.
- Consumes the vga_timing bus plus N per-layer rgb/valid pairs, pixel-aligned with the timing inputs, from the draw modules.
- Produces a resolved pixel with per-layer opaque or 50% blend modes and a frame-synchronous layer-enable mask.
- Sits between the draw_* layers and draw_mouse.

Parameters:
- N_LAYERS, 4: number of layer inputs; layer 0 has the highest priority; legal range 1..8.
- RGB_W, 12: pixel width, 4 bits per channel.
- BG_RGB, 12'h000: colour shown when no enabled layer is valid.
- BLEND_MASK, 0: bit i set means layer i is blended 50% with the colour resolved beneath it; bit clear means opaque.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- hcount_in  in  11  from vga_timing
- vcount_in  in  11  from vga_timing
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing strobes
- layer_rgb_in  in  N_LAYERS*RGB_W  packed; layer i occupies bits [i*RGB_W +: RGB_W]
- layer_valid_in  in  N_LAYERS  pixel of layer i is non-transparent
- layer_en_req  in  N_LAYERS  requested enable mask
- layer_en_wr  in  1  one-cycle strobe that captures layer_en_req
- layer_en_active  out  N_LAYERS  mask currently in effect
- hcount_out, vcount_out  out  11  delayed timing
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed strobes
- rgb_out  out  RGB_W  resolved pixel
- top_layer  out  3  index of the highest-priority contributing layer; 7 when the background is shown
- frame_cnt  out  16  completed-frame counter

Behaviour:
- Reset: all timing outputs are 0, rgb_out is 0, top_layer is 7, frame_cnt is 0, layer_en_active is all ones, the pending request is cleared.
- Latency: fixed 2 cycles from every input to every output; timing and rgb stay mutually aligned.
  - Stage 1 registers the timing signals, rgb, valid and the active mask.
  - Stage 2 registers the resolved colour and applies blanking.
- Resolve order, in stage 2 combinational logic:
  - Start with c = BG_RGB.
  - For i from N_LAYERS-1 down to 0: if valid[i] and en[i], then c = BLEND_MASK[i] ? avg(rgb_i, c) : rgb_i.
  - avg works per 4-bit channel: (a+b)>>1 with 5-bit intermediate, truncated.
  - top_layer is the lowest i that contributed.
- Blanking: if delayed hblnk or vblnk is set, rgb_out is 0. top_layer is still reported.
- Frame edge: the cycle in which vblnk_in is 1 and its previous registered value is 0.
- Enable shadowing:
  - layer_en_wr loads pending_mask and sets pending_flag.
  - On a frame edge with pending_flag set, layer_en_active takes pending_mask and pending_flag clears.
  - The mask never changes mid-frame.
- Simultaneous layer_en_wr and frame edge: the new request is applied at that edge directly.
- Several writes within one frame: the last one wins.
- frame_cnt increments on every frame edge and wraps from 16'hFFFF to 0.
- Reset mid-frame: the pipeline flushes to reset values. The first frame edge after reset still counts.
- When N_LAYERS < 8, the unused index space is ignored. top_layer = 7 is reserved for background, so N_LAYERS = 8 maps layer 7 and background to the same code; this is accepted and documented.

Decomposition:
- Package vga_mix_pkg holds:
  - RGB_W and the channel width;
  - typedef rgb_t;
  - function rgb_avg;
  - constant TOP_NONE = 3'd7;
  - constant MIX_LATENCY = 2, so other stages can align sideband signals.
- Sub-module vga_mix_resolve: purely combinational priority/blend loop over N_LAYERS. The parent holds the pipeline registers, the shadow mask and the frame counter.

Test Plan:
- Opaque priority: N=4, BLEND_MASK=0. Layer 0 rgb 12'hF00 and layer 2 rgb 12'h0F0, both valid, in active video. rgb_out = 12'hF00 and top_layer = 0 exactly 2 cycles later. Drop valid[0]: rgb_out = 12'h0F0, top_layer = 2.
- Blend: BLEND_MASK=4'b0001, layer 0 = 12'hF00, layer 1 = 12'h0F0, both valid. rgb_out = 12'h770 (15>>1=7 in R, 15>>1=7 in G).
- Background and blanking: no valid layers, BG_RGB=12'h123. rgb_out = 12'h123, top_layer = 7. Assert hblnk_in: rgb_out = 0 two cycles later while hsync_out tracks hsync_in delayed by 2.
- Frame-synchronous mask:
  - Pulse layer_en_wr with 4'b1110 mid-frame. layer_en_active stays 4'b1111 until the next vblnk rise, then becomes 4'b1110.
  - A layer 0 pixel at 12'hF00 is visible before the change and suppressed after it.
- Simultaneous and repeated writes:
  - Writes 4'b0011 then 4'b0101 in one frame: 4'b0101 is applied.
  - A write coincident with the vblnk rise is applied on that same edge.
- Counter and reset: run 3 frames, frame_cnt = 3. Assert rst mid-line: all outputs return to reset values next cycle, layer_en_active = 4'b1111. Preload the counter to 16'hFFFF via force, then one frame edge gives 0.
